// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C register-file target.
// Holds the FSM state encoding, bus-level ACK/NACK values, the R/W bit
// position in the address byte, and the register-index width helper.
package i2c_slave_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEV_ADDR,
        DEV_ACK,
        REG_ADDR,
        REG_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } state_e;

    // SDA level seen on the bus during the acknowledge slot
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // Position of the read/write flag in the device address byte
    localparam int RW_BIT = 0;

    // Register index width: max(1, clog2(n))
    function automatic int addr_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchroniser and bus-condition detector for the I2C target.
// Both lines go through the same number of flops so their relative timing
// is preserved; edges and START/STOP are derived from the synced copies.
// Flops reset to 1 because an idle I2C bus floats high.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_pulse,
    output logic stop_pulse
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   scl_s;

    // Next-state of the synchroniser chains and the one-cycle history flops
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_prev_d = scl_sync_q[SYNC_STAGES-1];
        sda_prev_d = sda_sync_q[SYNC_STAGES-1];
    end

    // Register the chains; asynchronous active-low reset to bus-idle level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl_s       = scl_sync_q[SYNC_STAGES-1];
    assign sda_s       = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise    =  scl_s & ~scl_prev_q;
    assign scl_fall    = ~scl_s &  scl_prev_q;
    // SDA may only move while SCL is high for a bus condition
    assign start_pulse = scl_s & scl_prev_q &  sda_prev_q & ~sda_s;
    assign stop_pulse  = scl_s & scl_prev_q & ~sda_prev_q &  sda_s;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with an on-chip register file, oversampled on the system clock.
// Optional feature macro: I2C_SLAVE_AUTOINC_EN -- when defined, the register
// pointer advances after every written or read byte (wrapping to 0); when
// undefined the pointer stays put between data bytes.
// Bits are sampled on the synced SCL rising edge; SDA drive only changes in
// the cycle after a synced SCL falling edge, so the target never creates a
// false START/STOP. START/STOP take priority over every state.
module i2c_slave_regfile
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         NUM_REGS    = 8,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RESET_VAL   = 8'h00
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               scl,
    input  logic                               sda_in,
    output logic                               sda_oe,
    output logic                               busy,
    output logic                               start_det,
    output logic                               stop_det,
    output logic                               reg_wr_stb,
    output logic [addr_width(NUM_REGS)-1:0]    reg_wr_addr,
    output logic [7:0]                         reg_wr_data,
    output logic [NUM_REGS*8-1:0]              regs_flat
);

    localparam int            AW       = addr_width(NUM_REGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);
`ifdef I2C_SLAVE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic scl_rise, scl_fall, sda_s, bus_start, bus_stop;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk         (clk),
        .rst         (rst),
        .scl         (scl),
        .sda_in      (sda_in),
        .scl_rise    (scl_rise),
        .scl_fall    (scl_fall),
        .sda_s       (sda_s),
        .start_pulse (bus_start),
        .stop_pulse  (bus_stop)
    );

    state_e          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [6:0]      shift_q, shift_d;     // 7 stored bits; 8th comes live from sda_s
    logic [AW-1:0]   ptr_q, ptr_d;
    logic            rw_q, rw_d;
    logic            slot_rise_q, slot_rise_d; // ACK slot clock has risen
    logic            sda_oe_q, sda_oe_d;
    logic            busy_q, busy_d;
    logic            start_det_q, start_det_d;
    logic            stop_det_q, stop_det_d;
    logic            wr_stb_q, wr_stb_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic [7:0]      regs_q [NUM_REGS];
    logic [7:0]      rx_byte;
    logic [7:0]      rd_byte;
    logic            byte_done;

    function automatic logic [AW-1:0] ptr_advance(input logic [AW-1:0] p);
        if (!AUTOINC) begin
            return p;
        end
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Protocol FSM, shifter and pointer next-state
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        slot_rise_d = slot_rise_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        start_det_d = 1'b0;
        stop_det_d  = 1'b0;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rx_byte     = {shift_q, sda_s};
        rd_byte     = regs_q[ptr_q];
        byte_done   = scl_rise && (bit_cnt_q == 3'd0);

        if (bus_start) begin
            state_d     = DEV_ADDR;
            bit_cnt_d   = 3'd7;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b1;
            start_det_d = 1'b1;
        end else if (bus_stop) begin
            state_d    = IDLE;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            stop_det_d = 1'b1;
        end else begin
            case (state_q)
                DEV_ADDR, REG_ADDR, WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q - 3'd1; // wraps 0 -> 7 for the next byte
                    end
                    if (byte_done) begin
                        slot_rise_d = 1'b0;
                        if (state_q == DEV_ADDR) begin
                            rw_d    = rx_byte[RW_BIT];
                            state_d = (rx_byte[7:1] == SLAVE_ADDR) ? DEV_ACK : IGNORE;
                        end else if (state_q == REG_ADDR) begin
                            if ({1'b0, rx_byte} < 9'(NUM_REGS)) begin
                                ptr_d   = rx_byte[AW-1:0];
                                state_d = REG_ACK;
                            end else begin
                                state_d = IGNORE;
                            end
                        end else begin
                            wr_stb_d  = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = rx_byte;
                            ptr_d     = ptr_advance(ptr_q);
                            state_d   = WR_ACK;
                        end
                    end
                end
                DEV_ACK, REG_ACK, WR_ACK: begin
                    if (scl_rise) begin
                        slot_rise_d = 1'b1;
                    end
                    if (scl_fall) begin
                        if (!slot_rise_q) begin
                            sda_oe_d = ~ACK;
                        end else begin
                            bit_cnt_d = 3'd7;
                            if (state_q == DEV_ACK && rw_q) begin
                                state_d  = RD_DATA;
                                shift_d  = rd_byte[6:0];
                                sda_oe_d = ~rd_byte[7];
                            end else begin
                                state_d  = (state_q == DEV_ACK) ? REG_ADDR : WR_DATA;
                                sda_oe_d = 1'b0;
                            end
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        sda_oe_d = ~shift_q[6];
                        shift_d  = {shift_q[5:0], 1'b0};
                    end
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        if (bit_cnt_q == 3'd0) begin
                            state_d     = RD_ACK;
                            slot_rise_d = 1'b0;
                            ptr_d       = ptr_advance(ptr_q);
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_fall) begin
                        if (!slot_rise_q) begin
                            sda_oe_d = 1'b0;
                        end else begin
                            state_d   = RD_DATA;
                            bit_cnt_d = 3'd7;
                            shift_d   = rd_byte[6:0];
                            sda_oe_d  = ~rd_byte[7];
                        end
                    end
                    if (scl_rise) begin
                        if (sda_s == NACK) begin
                            state_d = IGNORE;
                        end else begin
                            slot_rise_d = 1'b1;
                        end
                    end
                end
                default: begin
                    // IDLE and IGNORE wait for the next bus condition
                end
            endcase
        end
    end

    // FSM and registered-output flops; reset releases SDA immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd7;
            shift_q     <= '0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            slot_rise_q <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            slot_rise_q <= slot_rise_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            start_det_q <= start_det_d;
            stop_det_q  <= stop_det_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Register file; written in the same cycle the strobe is registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else if (wr_stb_d) begin
            regs_q[wr_addr_d] <= wr_data_d;
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign regs_flat[8*gi +: 8] = regs_q[gi];
    end

    assign sda_oe      = sda_oe_q;
    assign busy        = busy_q;
    assign start_det   = start_det_q;
    assign stop_det    = stop_det_q;
    assign reg_wr_stb  = wr_stb_q;
    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: an I2C master model drives SCL/SDA at 1/20 of
// clk; a register/pointer model predicts ACKs, read data, write strobes and
// the register image. Table-driven transactions, hand-written corner cases,
// then random transactions.
module tb_i2c_slave_regfile;

    localparam int NREG = 8;
`ifdef I2C_SLAVE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              m_scl = 1'b1;
    logic              m_sda = 1'b1;
    logic              sda_bus;
    logic              sda_oe, busy, start_det, stop_det, reg_wr_stb;
    logic [2:0]        reg_wr_addr;
    logic [7:0]        reg_wr_data;
    logic [NREG*8-1:0] regs_flat;

    assign sda_bus = m_sda & ~sda_oe;

    i2c_slave_regfile #(
        .SLAVE_ADDR  (7'h50),
        .NUM_REGS    (NREG),
        .SYNC_STAGES (2),
        .RESET_VAL   (8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst_n),
        .scl         (m_scl),
        .sda_in      (sda_bus),
        .sda_oe      (sda_oe),
        .busy        (busy),
        .start_det   (start_det),
        .stop_det    (stop_det),
        .reg_wr_stb  (reg_wr_stb),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .regs_flat   (regs_flat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd;
        logic [6:0]  dev;
        logic [7:0]  ra;
        logic [2:0]  n;
        logic [31:0] d;
        logic        exp_dev_ack;
        logic        exp_reg_ack;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  m_regs [NREG];
    int          m_ptr;

    // Monitor-owned logs (only written here)
    logic [18:0] stb_log [$];
    int          oe_cnt = 0, start_cnt = 0, stop_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_wr_stb) stb_log.push_back({reg_wr_addr, reg_wr_data, regs_flat[int'(reg_wr_addr)*8 +: 8]});
            if (sda_oe)    oe_cnt++;
            if (start_det) start_cnt++;
            if (stop_det)  stop_cnt++;
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog: sim time exceeded, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic w(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        if (!m_scl) begin
            m_sda = 1'b1; w(5);
            m_scl = 1'b1; w(5);
        end
        m_sda = 1'b0; w(5);
        m_scl = 1'b0; w(5);
    endtask

    task automatic do_stop();
        m_sda = 1'b0; w(5);
        m_scl = 1'b1; w(5);
        m_sda = 1'b1; w(10);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        m_sda = b;    w(5);
        m_scl = 1'b1; w(5);
        s = sda_bus;  w(5);
        m_scl = 1'b0; w(5);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic master_ack);
        logic s;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            clk_bit(1'b1, s);
            d = {d[6:0], s};
        end
        clk_bit(~master_ack, s);
    endtask

    function automatic logic [63:0] model_image();
        logic [63:0] img;
        for (int i = 0; i < NREG; i++) img[8*i +: 8] = m_regs[i];
        return img;
    endfunction

    function automatic vec_t mk(input logic rd, input logic [6:0] dev, input logic [7:0] ra,
                                input logic [2:0] n, input logic [31:0] d);
        vec_t v;
        v.rd = rd; v.dev = dev; v.ra = ra; v.n = n; v.d = d;
        v.exp_dev_ack = (dev == 7'h50);
        v.exp_reg_ack = (ra < NREG);
        return v;
    endfunction

    // Checks strobes logged since snapshot s_stb against the expected list
    task automatic check_strobes(input int s_stb, input logic [10:0] exp_stb [$]);
        chk("stb_count", stb_log.size() - s_stb, exp_stb.size());
        for (int i = 0; i < exp_stb.size() && s_stb + i < stb_log.size(); i++) begin
            chk("stb_addr_data", stb_log[s_stb+i][18:8], exp_stb[i]);
            chk("stb_reg_same_clk", stb_log[s_stb+i][7:0], stb_log[s_stb+i][15:8]);
        end
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        logic        ack;
        logic [7:0]  got, b;
        logic [10:0] exp_stb [$];
        int          s_stb, s_oe, s_start, s_stop, exp_starts;
        s_stb = stb_log.size(); s_oe = oe_cnt; s_start = start_cnt; s_stop = stop_cnt;
        exp_starts = 1;
        do_start();
        send_byte({v.dev, 1'b0}, ack);
        chk("dev_ack", ack, v.exp_dev_ack);
        chk("busy_mid", busy, 1);
        if (v.exp_dev_ack) begin
            send_byte(v.ra, ack);
            chk("reg_ack", ack, v.exp_reg_ack);
            if (v.exp_reg_ack) begin
                m_ptr = int'(v.ra);
                if (!v.rd) begin
                    for (int i = 0; i < int'(v.n); i++) begin
                        b = v.d[8*i +: 8];
                        send_byte(b, ack);
                        chk("wr_ack", ack, 1);
                        m_regs[m_ptr] = b;
                        exp_stb.push_back({3'(m_ptr), b});
                        if (AUTOINC) m_ptr = (m_ptr + 1) % NREG;
                    end
                end else begin
                    do_start();
                    exp_starts = 2;
                    send_byte({v.dev, 1'b1}, ack);
                    chk("rd_dev_ack", ack, 1);
                    for (int i = 0; i < int'(v.n); i++) begin
                        read_byte(got, i < int'(v.n) - 1);
                        chk("rd_data", got, m_regs[m_ptr]);
                        if (AUTOINC) m_ptr = (m_ptr + 1) % NREG;
                    end
                end
            end
        end
        do_stop();
        w(4);
        chk("busy_after_stop", busy, 0);
        chk("start_pulses", start_cnt - s_start, exp_starts);
        chk("stop_pulses", stop_cnt - s_stop, 1);
        check_strobes(s_stb, exp_stb);
        chk("regs_image", regs_flat, model_image());
        if (!v.exp_dev_ack) chk("no_drive_on_nack", oe_cnt - s_oe, 0);
        $display("txn %0d rd=%0d dev=%h reg=%h n=%0d data=%h ptr_after=%0d", idx, v.rd, v.dev, v.ra, v.n, v.d, m_ptr);
    endtask

    initial begin
        vec_t        tbl [5];
        vec_t        v;
        logic        ack, s;
        logic [7:0]  got;
        logic [10:0] no_stb [$];
        int          s_stb;

        tbl[0] = mk(1'b0, 7'h50, 8'h03, 3'd1, 32'h0000_00A5); // write A5 to reg3
        tbl[1] = mk(1'b0, 7'h51, 8'h00, 3'd1, 32'h0000_0077); // wrong address
        tbl[2] = mk(1'b0, 7'h50, 8'h06, 3'd3, 32'h0033_2211); // burst write from reg6
        tbl[3] = mk(1'b1, 7'h50, 8'h05, 3'd2, 32'h0);         // combined read of 2 bytes
        tbl[4] = mk(1'b0, 7'h50, 8'h09, 3'd1, 32'h0000_00EE); // register index out of range

        for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
        m_ptr = 0;

        w(3);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_regs", regs_flat, 64'h0);
        rst_n = 1'b1;
        w(3);
        chk("rst_pulses", {start_det, stop_det, reg_wr_stb}, 3'b000);

        for (int i = 0; i < 5; i++) run_txn(i, tbl[i]);

        chk("reg3_a5", regs_flat[31:24], 8'hA5);
        if (AUTOINC) begin
            chk("reg6_inc", regs_flat[55:48], 8'h11);
            chk("reg7_inc", regs_flat[63:56], 8'h22);
            chk("reg0_wrap", regs_flat[7:0], 8'h33);
        end else begin
            chk("reg6_static", regs_flat[55:48], 8'h33);
            chk("reg7_static", regs_flat[63:56], 8'h00);
        end

        // Current-address read: pointer must be unaffected by the rejected index
        do_start();
        send_byte({7'h50, 1'b1}, ack);
        chk("cur_rd_ack", ack, 1);
        read_byte(got, 1'b0);
        chk("cur_rd_data", got, m_regs[m_ptr]);
        if (AUTOINC) m_ptr = (m_ptr + 1) % NREG;
        do_stop();
        $display("txn cur_read data=%h", got);

        // STOP in the middle of a data byte: nothing is committed
        s_stb = stb_log.size();
        do_start();
        send_byte({7'h50, 1'b0}, ack);
        chk("part_dev_ack", ack, 1);
        send_byte(8'h02, ack);
        chk("part_reg_ack", ack, 1);
        m_ptr = 2;
        for (int i = 0; i < 4; i++) clk_bit(i[0], s);
        do_stop();
        w(4);
        check_strobes(s_stb, no_stb);
        chk("part_regs", regs_flat, model_image());
        $display("txn partial_stop");

        // Reset while the target drives the address ACK
        do_start();
        for (int i = 7; i >= 0; i--) clk_bit(got[0] ^ got[0] ^ ((8'hA0 >> i) & 1) ? 1'b1 : 1'b0, s);
        m_sda = 1'b1; w(5);
        m_scl = 1'b1; w(3);
        chk("ack_driven", sda_oe, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_release_sda", sda_oe, 0);
        chk("rst_clears_regs", regs_flat, 64'h0);
        w(2);
        rst_n = 1'b1;
        w(2);
        m_scl = 1'b0; w(5);
        do_stop();
        for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        $display("txn reset_during_ack");
        run_txn(100, tbl[0]);

        // Random transactions against the model
        for (int i = 0; i < 14; i++) begin
            v = mk(1'($urandom_range(0, 1)),
                   ($urandom_range(0, 4) == 0) ? 7'($urandom) : 7'h50,
                   8'($urandom_range(0, 10)),
                   3'($urandom_range(1, 3)),
                   $urandom);
            run_txn(200 + i, v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
